// File: rtl/ecp_alu_pkg.sv
// ecp_alu_pkg: shared width, opcode encoding and sequencer states for the field-arithmetic front end
package ecp_alu_pkg;
    localparam int ALU_WIDTH = 256;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;
    function automatic logic is_multi_cycle(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction
endpackage

// File: rtl/alu_watchdog.sv
// alu_watchdog: counts enabled cycles from zero and flags the last allowed cycle before giving up
module alu_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_count;
    // cycle counter, restarted whenever the sequencer is outside its wait phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_count <= '0;
        else if (i_clear) r_count <= '0;
        else if (i_enable) r_count <= r_count + CW'(1);
    end
    assign o_timeout = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one command, drives operands/starts to the units and returns the muxed result
module alu_op_sequencer
    import ecp_alu_pkg::*;
#(
    parameter int WIDTH          = ALU_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic signed [WIDTH-1:0] cmd_a,
    input  logic signed [WIDTH-1:0] cmd_b,
    output logic signed [WIDTH-1:0] op_a,
    output logic signed [WIDTH-1:0] op_b,
    output logic                    mul_start,
    input  logic                    mul_done,
    output logic                    div_start,
    input  logic                    div_done,
    output logic [1:0]              select,
    input  logic signed [WIDTH-1:0] final_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [WIDTH-1:0] res_data,
    output logic [1:0]              res_op,
    output logic                    res_err,
    output logic                    busy
);
    state_t                  r_state;
    state_t                  w_next;
    logic                    r_alive;
    logic signed [WIDTH-1:0] r_op_a;
    logic signed [WIDTH-1:0] r_op_b;
    logic [1:0]              r_sel;
    logic signed [WIDTH-1:0] r_res_data;
    logic [1:0]              r_res_op;
    logic                    r_res_err;
    logic                    r_res_valid;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_timeout;
    logic                    w_capture;
    logic                    w_err;

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_sel == OP_MUL) ? mul_done : div_done;
    assign w_capture = (r_state == S_EXEC) || ((r_state == S_WAIT) && (w_done || w_timeout));
    assign w_err     = (r_state == S_WAIT) && !w_done;

    alu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state != S_WAIT),
        .i_enable (r_state == S_WAIT),
        .o_timeout(w_timeout)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // next state: one command in flight, done beats timeout, release only once the result was shown valid
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (is_multi_cycle(cmd_op) ? S_ISSUE : S_EXEC) : S_IDLE;
            S_EXEC:  w_next = S_HOLD;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (w_done || w_timeout) ? S_HOLD : S_WAIT;
            S_HOLD:  w_next = (r_res_valid && res_ready) ? S_IDLE : S_HOLD;
            default: w_next = S_IDLE;
        endcase
    end

    // operand/select latch at accept, result capture, and the output valid stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alive     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sel       <= OP_ADD;
            r_res_op    <= OP_ADD;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_op_a   <= cmd_a;
                r_op_b   <= cmd_b;
                r_sel    <= cmd_op;
                r_res_op <= cmd_op;
            end
            if (w_capture) begin
                r_res_data <= w_err ? '0 : final_result;
                r_res_err  <= w_err;
            end
            r_res_valid <= (r_state == S_HOLD) && !(r_res_valid && res_ready);
        end
    end

    assign cmd_ready = r_alive && (r_state == S_IDLE);
    assign mul_start = (r_state == S_ISSUE) && (r_sel == OP_MUL);
    assign div_start = (r_state == S_ISSUE) && (r_sel == OP_DIV);
    assign busy      = r_state != S_IDLE;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign select    = r_sel;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
    assign res_err   = r_res_err;
    assign res_valid = r_res_valid;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenarios against a simple result-mux model with hand-computed results
module tb_alu_op_sequencer;
    localparam int W = 256;
    localparam logic signed [W-1:0] DIV_VAL = 256'sd123;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [1:0]          cmd_op = 2'd0;
    logic signed [W-1:0] cmd_a = '0;
    logic signed [W-1:0] cmd_b = '0;
    logic signed [W-1:0] op_a;
    logic signed [W-1:0] op_b;
    logic                mul_start;
    logic                mul_done = 1'b0;
    logic                div_start;
    logic                div_done = 1'b0;
    logic [1:0]          select;
    logic signed [W-1:0] final_result;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic signed [W-1:0] res_data;
    logic [1:0]          res_op;
    logic                res_err;
    logic                busy;
    int                  n_cmp = 0;
    int                  n_err = 0;
    int                  n_mul = 0;
    int                  n_div = 0;

    alu_op_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .op_a(op_a), .op_b(op_b), .mul_start(mul_start),
        .mul_done(mul_done), .div_start(div_start), .div_done(div_done), .select(select),
        .final_result(final_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        final_result = select == 2'd0 ? op_a + op_b :
                       select == 2'd1 ? op_a - op_b :
                       select == 2'd2 ? op_a * op_b : DIV_VAL;
    end

    always @(posedge clk) begin
        if (mul_start) n_mul++;
        if (div_start) n_div++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready got %0b want 0", cmd_ready); end
        n_cmp++; if ({busy, res_valid, mul_start, div_start, res_err} !== 5'b0) begin n_err++; $display("FAIL rst_flags got %b want 00000", {busy, res_valid, mul_start, div_start, res_err}); end
        n_cmp++; if ({op_a, op_b, res_data} !== '0) begin n_err++; $display("FAIL rst_data got %0h/%0h/%0h want 0", op_a, op_b, res_data); end
        n_cmp++; if ({select, res_op} !== 4'b0) begin n_err++; $display("FAIL rst_sel got %0d/%0d want 0/0", select, res_op); end
        rst = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_release_ready got %0b want 0", cmd_ready); end
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_rst got %0b want 1", cmd_ready); end
    endtask

    task automatic test_add();
        send(2'd0, 256'sd5, 256'sd7);
        n_cmp++; if (select !== 2'd0 || op_a !== 256'sd5 || op_b !== 256'sd7) begin n_err++; $display("FAIL add_latch got sel=%0d a=%0h b=%0h want 0/5/7", select, op_a, op_b); end
        n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL add_busy got ready=%0b busy=%0b want 0/1", cmd_ready, busy); end
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got %0b want 0", res_valid); end
        tick();
        n_cmp++; if (res_valid !== 1'b1 || res_data !== 256'sd12 || res_op !== 2'd0 || res_err !== 1'b0) begin n_err++; $display("FAIL add_result got v=%0b d=%0h op=%0d e=%0b want 1/c/0/0", res_valid, res_data, res_op, res_err); end
        release_result();
        n_cmp++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL add_release got v=%0b rdy=%0b want 0/1", res_valid, cmd_ready); end
    endtask

    task automatic test_sub_negative();
        send(2'd1, 256'sd3, 256'sd10);
        n_cmp++; if (select !== 2'd1) begin n_err++; $display("FAIL sub_select got %0d want 1", select); end
        tick(); tick();
        n_cmp++; if (res_valid !== 1'b1 || res_data !== -256'sd7 || res_op !== 2'd1) begin n_err++; $display("FAIL sub_result got v=%0b d=%0h op=%0d want 1/-7/1", res_valid, res_data, res_op); end
        release_result();
    endtask

    task automatic test_mul();
        int bm;
        int bd;
        logic signed [W-1:0] a;
        logic signed [W-1:0] want;
        a = 256'sd1 << 200;
        want = 256'sd1 << 202;
        bm = n_mul; bd = n_div;
        send(2'd2, a, 256'sd4);
        n_cmp++; if (mul_start !== 1'b1 || div_start !== 1'b0 || select !== 2'd2) begin n_err++; $display("FAIL mul_issue got ms=%0b ds=%0b sel=%0d want 1/0/2", mul_start, div_start, select); end
        tick();
        n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL mul_start_width got %0b want 0", mul_start); end
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL mul_wait got v=%0b busy=%0b want 0/1", res_valid, busy); end
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        n_cmp++; if (res_data !== want || res_err !== 1'b0) begin n_err++; $display("FAIL mul_capture got d=%0h e=%0b want %0h/0", res_data, res_err, want); end
        tick();
        n_cmp++; if (res_valid !== 1'b1 || res_op !== 2'd2) begin n_err++; $display("FAIL mul_valid got v=%0b op=%0d want 1/2", res_valid, res_op); end
        n_cmp++; if (n_mul - bm !== 1 || n_div - bd !== 0) begin n_err++; $display("FAIL mul_pulses got mul=%0d div=%0d want 1/0", n_mul - bm, n_div - bd); end
        release_result();
    endtask

    task automatic test_div_timeout();
        int bd;
        logic signed [W-1:0] prev;
        prev = res_data;
        bd = n_div;
        send(2'd3, 256'sd100, 256'sd7);
        n_cmp++; if (div_start !== 1'b1 || mul_start !== 1'b0) begin n_err++; $display("FAIL div_issue got ds=%0b ms=%0b want 1/0", div_start, mul_start); end
        tick();
        for (int i = 0; i < 15; i++) begin
            mul_done = (i == 2);
            tick();
        end
        mul_done = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || res_err !== 1'b0 || res_data !== prev || busy !== 1'b1) begin n_err++; $display("FAIL div_before_timeout got v=%0b e=%0b d=%0h want 0/0/%0h", res_valid, res_err, res_data, prev); end
        tick();
        n_cmp++; if (res_err !== 1'b1 || res_data !== '0) begin n_err++; $display("FAIL div_timeout got e=%0b d=%0h want 1/0", res_err, res_data); end
        tick();
        n_cmp++; if (res_valid !== 1'b1 || res_op !== 2'd3 || n_div - bd !== 1) begin n_err++; $display("FAIL div_hold got v=%0b op=%0d pulses=%0d want 1/3/1", res_valid, res_op, n_div - bd); end
        release_result();
    endtask

    task automatic test_done_vs_timeout();
        send(2'd2, 256'sd3, 256'sd5);
        tick();
        for (int i = 0; i < 15; i++) tick();
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        n_cmp++; if (res_err !== 1'b0 || res_data !== 256'sd15) begin n_err++; $display("FAIL done_wins got e=%0b d=%0h want 0/f", res_err, res_data); end
        tick();
        release_result();
    endtask

    task automatic test_back_to_back();
        send(2'd0, 256'sd100, -256'sd1);
        tick(); tick();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 256'sd50; cmd_b = 256'sd8;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 256'sd99) begin n_err++; $display("FAIL backpressure_%0d got rdy=%0b v=%0b d=%0h want 0/1/63", i, cmd_ready, res_valid, res_data); end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release got v=%0b busy=%0b rdy=%0b want 0/0/1", res_valid, busy, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || select !== 2'd1 || op_a !== 256'sd50) begin n_err++; $display("FAIL b2b_accept got busy=%0b sel=%0d a=%0h want 1/1/32", busy, select, op_a); end
        tick(); tick();
        n_cmp++; if (res_valid !== 1'b1 || res_data !== 256'sd42) begin n_err++; $display("FAIL b2b_result got v=%0b d=%0h want 1/2a", res_valid, res_data); end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        send(2'd2, 256'sd6, 256'sd7);
        rst = 1'b1;
        #1;
        n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL rst_cut_start got %0b want 0", mul_start); end
        tick();
        rst = 1'b0;
        tick();
        send(2'd2, 256'sd6, 256'sd7);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, cmd_ready, res_valid, res_err, mul_start} !== 5'b0) begin n_err++; $display("FAIL rst_mid_flags got %b want 00000", {busy, cmd_ready, res_valid, res_err, mul_start}); end
        n_cmp++; if (op_a !== '0 || res_data !== '0 || select !== 2'd0 || res_op !== 2'd0) begin n_err++; $display("FAIL rst_mid_regs got a=%0h d=%0h sel=%0d op=%0d want 0", op_a, res_data, select, res_op); end
        tick();
        rst = 1'b0;
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        tick(); tick();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL late_done got v=%0b busy=%0b rdy=%0b want 0/0/1", res_valid, busy, cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_negative();
        test_mul();
        test_div_timeout();
        test_done_vs_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
